pio_edge_poll_ctrl: RTL

Avalon-MM master that sequences the 8-bit edge-capturing input PIO carrying the audio filter's push-buttons/switches. On a programmable poll interval it reads the PIO edge-capture register, write-clears it, snapshots the input levels, and turns captured edges into a queue of single-bit events. An arbiter hands these events one at a time to the filter-control logic over a valid/ready handshake.

---
 rtl/pio_poll_pkg.sv | 25 ++
 rtl/pio_edge_poll_ctrl_if.sv | 28 ++
 rtl/pio_evt_arbiter.sv | 86 ++++++++
 rtl/pio_edge_poll_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/pio_poll_pkg.sv
// Shared definitions for the edge-capturing PIO poller: register offsets,
// poll FSM states and the overrun counter width.
package pio_poll_pkg;

  localparam logic [1:0] PIO_REG_DATA = 2'd0;
  localparam logic [1:0] PIO_REG_EDGE = 2'd3;
  localparam int         OVR_CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    CAP_ADDR,
    CAP_SAMPLE,
    CLEAR,
    LVL_ADDR,
    LVL_SAMPLE
  } poll_state_t;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/pio_edge_poll_ctrl_if.sv
// Avalon-MM bus to the edge-capturing PIO plus the event valid/ready
// handshake toward the filter-control logic.
interface pio_edge_poll_ctrl_if #(
  parameter int N = 8
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]     pio_address;
  logic           pio_chipselect;
  logic           pio_write_n;
  logic [31:0]    pio_writedata;
  logic [31:0]    pio_readdata;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;

  modport master (
    output pio_address, pio_chipselect, pio_write_n, pio_writedata,
    output evt_valid, evt_id,
    input  pio_readdata, evt_ready
  );

  modport slave (
    input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
    input  evt_valid, evt_id,
    output pio_readdata, evt_ready
  );
endinterface

// File: rtl/pio_evt_arbiter.sv
// Pending-event register and grant logic. Fixed lowest-index priority by
// default; define PIO_POLL_RR_EN for a round-robin grant held until accepted.
module pio_evt_arbiter #(
  parameter int N = 8,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           set_en_i,
  input  logic [N-1:0]   set_mask_i,
  input  logic           ready_i,
  output logic           valid_o,
  output logic [IDW-1:0] id_o,
  output logic [N-1:0]   held_o
);

  logic [N-1:0]   pending_q;
  logic [N-1:0]   pending_d;
  logic [N-1:0]   clr_mask;
  logic [IDW-1:0] grant_id;
  logic           hs;

  assign valid_o = |pending_q;
  assign id_o    = grant_id;
  assign hs      = valid_o && ready_i;

  for (genvar gi = 0; gi < N; gi++) begin : g_clr
    assign clr_mask[gi] = hs && (grant_id == IDW'(gi));
  end

  // Bits surviving this edge before new captures; a same-cycle set wins.
  assign held_o    = pending_q & ~clr_mask;
  assign pending_d = held_o | (set_en_i ? set_mask_i : '0);

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

`ifdef PIO_POLL_RR_EN
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] lock_id_q;
  logic           lock_q;
  logic [IDW-1:0] search_id;
  logic           found;
  int             idx;

  always_comb begin
    search_id = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && pending_q[IDW'(idx)]) begin
        search_id = IDW'(idx);
        found     = 1'b1;
      end
    end
  end

  // An offered but unaccepted event keeps its grant until the handshake.
  assign grant_id = lock_q ? lock_id_q : search_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (hs) begin
      ptr_q  <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
      lock_q <= 1'b0;
    end else if (valid_o) begin
      lock_q    <= 1'b1;
      lock_id_q <= grant_id;
    end
  end
`else
  always_comb begin
    grant_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) grant_id = IDW'(i);
    end
  end
`endif

endmodule

// File: rtl/pio_edge_poll_ctrl.sv
// Polls an edge-capturing PIO every POLL_DIV idle cycles and queues captured
// edges as single-bit events. Optional round-robin grant: PIO_POLL_RR_EN.
module pio_edge_poll_ctrl
  import pio_poll_pkg::*;
#(
  parameter int N        = 8,
  parameter int POLL_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  pio_edge_poll_ctrl_if.master bus,
  output logic [N-1:0]         sw_level,
  output logic [OVR_CNT_W-1:0] overrun_cnt
);

  localparam int          CNT_W   = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(POLL_DIV - 1);
  localparam int unsigned OVR_MAX = (2 ** OVR_CNT_W) - 1;

  poll_state_t          state_q;
  logic [CNT_W-1:0]     poll_cnt_q;
  logic [1:0]           addr_q;
  logic                 cs_q;
  logic                 write_n_q;
  logic [N-1:0]         sw_level_q;
  logic [OVR_CNT_W-1:0] overrun_q;
  logic [OVR_CNT_W-1:0] overrun_d;
  logic [N-1:0]         cap;
  logic [N-1:0]         held;
  logic                 cap_en;
  int unsigned          ovr_sum;

  assign cap    = bus.pio_readdata[N-1:0];
  assign cap_en = (state_q == CAP_SAMPLE);

  pio_evt_arbiter #(.N(N)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (cap_en),
    .set_mask_i (cap),
    .ready_i    (bus.evt_ready),
    .valid_o    (bus.evt_valid),
    .id_o       (bus.evt_id),
    .held_o     (held)
  );

  // Only captures landing on a bit that stays pending count as overruns.
  always_comb begin
    ovr_sum   = 32'(overrun_q) + popcount(32'(cap & held));
    overrun_d = (ovr_sum > OVR_MAX) ? OVR_CNT_W'(OVR_MAX) : OVR_CNT_W'(ovr_sum);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      poll_cnt_q <= CNT_LOAD;
      addr_q     <= PIO_REG_DATA;
      cs_q       <= 1'b0;
      write_n_q  <= 1'b1;
      sw_level_q <= '0;
      overrun_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (poll_cnt_q == '0) begin
            state_q    <= CAP_ADDR;
            poll_cnt_q <= CNT_LOAD;
            addr_q     <= PIO_REG_EDGE;
            cs_q       <= 1'b1;
          end else begin
            poll_cnt_q <= poll_cnt_q - 1'b1;
          end
        end
        CAP_ADDR: begin
          state_q <= CAP_SAMPLE;
          cs_q    <= 1'b0;
        end
        CAP_SAMPLE: begin
          state_q   <= CLEAR;
          overrun_q <= overrun_d;
          cs_q      <= 1'b1;
          write_n_q <= 1'b0;
        end
        CLEAR: begin
          state_q   <= LVL_ADDR;
          addr_q    <= PIO_REG_DATA;
          write_n_q <= 1'b1;
        end
        LVL_ADDR: begin
          state_q <= LVL_SAMPLE;
          cs_q    <= 1'b0;
        end
        LVL_SAMPLE: begin
          state_q    <= IDLE;
          sw_level_q <= cap;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pio_address    = addr_q;
  assign bus.pio_chipselect = cs_q;
  assign bus.pio_write_n    = write_n_q;
  assign bus.pio_writedata  = '0;
  assign sw_level           = sw_level_q;
  assign overrun_cnt        = overrun_q;

endmodule
